// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects operand A, operand B and an opcode from a UART
// receiver, presents them to an external combinational ALU, and hands the
// result to a UART transmitter. Partial frames are aborted after a bounded
// number of baud ticks; bytes that arrive while the result is in flight are
// dropped and flagged.
module alu_uart_ctrl #(
    parameter int BITS_DATA     = 8,
    parameter int BITS_OP       = 6,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 rx_done_tick,
    input  logic [BITS_DATA-1:0] rx_data,
    input  logic                 s_tick,
    input  logic                 tx_done_tick,
    input  logic [BITS_DATA-1:0] i_alu_result,
    output logic [BITS_DATA-1:0] o_data_a,
    output logic [BITS_DATA-1:0] o_data_b,
    output logic [BITS_OP-1:0]   o_op,
    output logic                 tx_start,
    output logic [BITS_DATA-1:0] tx_data,
    output logic                 o_timeout,
    output logic                 o_overrun
);

    // One extra bit so the counter can represent the limit itself without wrapping.
    localparam int CNT_W = $clog2(TIMEOUT_TICKS) + 1;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_expire;

    // This s_tick is the one that brings the counter up to the limit.
    assign w_expire = s_tick && (r_cnt == CNT_W'(TIMEOUT_TICKS - 1));

    // Frame sequencing FSM; every output is a register driven from here.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= WAIT_A;
            r_cnt     <= '0;
            o_data_a  <= '0;
            o_data_b  <= '0;
            o_op      <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
            case (r_state)
                WAIT_A: begin
                    r_cnt <= '0;
                    if (rx_done_tick) begin
                        o_data_a <= rx_data;
                        r_state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A byte wins over an expiring tick in the same cycle.
                    if (rx_done_tick) begin
                        o_data_b <= rx_data;
                        r_cnt    <= '0;
                        r_state  <= WAIT_OP;
                    end else if (w_expire) begin
                        r_cnt     <= '0;
                        o_timeout <= 1'b1;
                        r_state   <= WAIT_A;
                    end else if (s_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_OP: begin
                    if (rx_done_tick) begin
                        o_op    <= rx_data[BITS_OP-1:0];
                        r_cnt   <= '0;
                        r_state <= EXEC;
                    end else if (w_expire) begin
                        r_cnt     <= '0;
                        o_timeout <= 1'b1;
                        r_state   <= WAIT_A;
                    end else if (s_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    // Operands/opcode have been stable for a full cycle here.
                    tx_data   <= i_alu_result;
                    tx_start  <= 1'b1;
                    o_overrun <= rx_done_tick;
                    r_state   <= SEND;
                end
                SEND: begin
                    o_overrun <= rx_done_tick;
                    r_state   <= WAIT_TX;
                end
                WAIT_TX: begin
                    o_overrun <= rx_done_tick;
                    if (tx_done_tick) begin
                        r_cnt   <= '0;
                        r_state <= WAIT_A;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl: expected results are queued when the
// opcode byte is driven and popped when tx_start is seen.
module tb_alu_uart_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       s_tick = 1'b0;
    logic       tx_done_tick = 1'b0;
    logic [7:0] i_alu_result;
    logic [7:0] o_data_a, o_data_b, tx_data;
    logic [5:0] o_op;
    logic       tx_start, o_timeout, o_overrun;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_to = 0;
    int   n_ov = 0;

    alu_uart_ctrl #(.BITS_DATA(8), .BITS_OP(6), .TIMEOUT_TICKS(1024)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .s_tick(s_tick), .tx_done_tick(tx_done_tick),
        .i_alu_result(i_alu_result),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op),
        .tx_start(tx_start), .tx_data(tx_data),
        .o_timeout(o_timeout), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    always_comb i_alu_result = alu_f(o_data_a, o_data_b, o_op);

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor: scoreboard pop on tx_start, pulse counters.
    always @(negedge i_clk) begin
        if (o_timeout) n_to++;
        if (o_overrun) n_ov++;
        if (tx_start) begin
            if (sb.size() == 0) begin
                chk("tx_start_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tx_data", tx_data, e.data);
                chk("tx_latency_cyc", cyc, e.cyc);
            end
        end
    end

    // All tasks are entered at a negedge and leave at a negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        @(negedge i_clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        exp_t e;
        e.data = alu_f(a, b, op[5:0]);
        e.cyc  = cyc + 2;
        sb.push_back(e);
        send_byte(op);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_op(a, b, op);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge i_clk);
        chk(tag, sb.size(), 0);
    endtask

    task automatic finish_tx();
        tx_done_tick = 1'b1;
        @(negedge i_clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            s_tick = 1'b1;
            @(negedge i_clk);
            s_tick = 1'b0;
            @(negedge i_clk);
        end
    endtask

    initial begin
        int to0, ov0;
        #1;
        chk("rst_data_a", o_data_a, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Basic frame and latency
        frame(8'h05, 8'h03, 8'h20);
        chk("basic_a", o_data_a, 8'h05);
        chk("basic_b", o_data_b, 8'h03);
        chk("basic_op", o_op, 6'h20);
        drain("basic_sb");
        chk("basic_tx_data_hold", tx_data, 8'h08);
        finish_tx();

        // Back-to-back frame, upper opcode bits dropped
        frame(8'h0F, 8'h3C, 8'hE4);
        chk("op_mask", o_op, 6'h24);
        drain("mask_sb");
        finish_tx();

        // tx_done while collecting is ignored
        send_byte(8'h01);
        finish_tx();
        send_byte(8'h02);
        send_op(8'h01, 8'h02, 8'h26);
        drain("txdone_ign_sb");
        finish_tx();

        // Timeout after operand A
        to0 = n_to;
        send_byte(8'h11);
        ticks(1023);
        chk("to_early", n_to, to0);
        ticks(1);
        @(negedge i_clk);
        chk("to_pulse", n_to, to0 + 1);
        chk("to_keep_a", o_data_a, 8'h11);
        frame(8'h02, 8'h02, 8'h20);
        chk("to_next_a", o_data_a, 8'h02);
        drain("to_sb");
        finish_tx();

        // Byte coincides with the expiring tick in WAIT_B
        to0 = n_to;
        send_byte(8'h30);
        ticks(1023);
        s_tick = 1'b1;
        send_byte(8'h09);
        s_tick = 1'b0;
        @(negedge i_clk);
        chk("coinc_no_to", n_to, to0);
        chk("coinc_b", o_data_b, 8'h09);
        send_op(8'h30, 8'h09, 8'h22);
        drain("coinc_sb");
        finish_tx();

        // Overrun in WAIT_TX
        ov0 = n_ov;
        frame(8'h0A, 8'h05, 8'h22);
        drain("ov_sb");
        send_byte(8'hFF);
        @(negedge i_clk);
        chk("ov_pulse", n_ov, ov0 + 1);
        chk("ov_tx_data", tx_data, 8'h05);
        finish_tx();
        frame(8'h03, 8'h04, 8'h25);
        chk("ov_next_a", o_data_a, 8'h03);
        drain("ov_next_sb");
        finish_tx();

        // Asynchronous reset mid-frame
        send_byte(8'h05);
        send_byte(8'h03);
        #2 i_reset = 1'b1;
        #1;
        chk("arst_a", o_data_a, 0);
        chk("arst_b", o_data_b, 0);
        chk("arst_op", o_op, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_flags", {tx_start, o_timeout, o_overrun}, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (3) @(negedge i_clk);
        frame(8'h07, 8'h01, 8'h20);
        chk("arst_next_a", o_data_a, 8'h07);
        drain("arst_sb");
        finish_tx();

        repeat (2) @(negedge i_clk);
        chk("total_timeouts", n_to, 1);
        chk("total_overruns", n_ov, 1);
        chk("sb_final", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
